// File: rtl/disp_mux8.sv
// disp_mux8 -- frame-buffered 8-digit seven-segment display multiplexer.
//
// Captures the data/pos digit stream that the calculator core emits while
// printing (status=11) into a shadow buffer. The shadow buffer is committed to
// the display buffer as one complete frame on the 11->10 status transition.
// The display buffer is scanned across 8 multiplexed digits. An error status
// (00) overlays "Err" until the next successful commit.
//
// Optional feature: define DISP_LZB_EN to enable leading-zero blanking. The
// default build shows all 8 digits, including leading zeros.
//
// Ports:
//   clock   in   1  single clock; all state changes on posedge
//   reset   in   1  asynchronous, active-low reset
//   status  in   2  core status: 00 error, 01 busy, 10 ready, 11 printing
//   data    in   4  BCD digit from the core; 10..15 display blank
//   pos     in   4  core position; 1..8 selects digit pos-1, other values ignored
//   an      out  8  anode enables, active-low, one-hot-low (an[0] = rightmost)
//   seg     out  7  segments {g,f,e,d,c,b,a}, active-low
//   err     out  1  high while the error frame is displayed

module disp_mux8 #(
  parameter int REFRESH_DIV = 50000,
  parameter int NDIG        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Active-low segment pattern for one BCD value; 10..15 are blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // State
  logic [1:0]    status_q;
  logic [3:0]    shadow_q  [NDIG];
  logic [3:0]    shadow_d  [NDIG];
  logic [3:0]    display_q [NDIG];
  logic [3:0]    display_d [NDIG];
  logic          err_q, err_d;
  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [2:0]    scan_idx_q, scan_idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  // Status-transition decode
  logic       frame_start;
  logic       commit;
  logic       wr_en;
  logic [3:0] pos_m1;
  logic [2:0] wr_idx;

  assign frame_start = (status == ST_PRINT) && (status_q != ST_PRINT);
  assign commit      = (status == ST_READY) && (status_q == ST_PRINT);
  assign wr_en       = (status == ST_PRINT) && (pos >= 4'd1) && (pos <= 4'd8);
  assign pos_m1      = pos - 4'd1;
  assign wr_idx      = pos_m1[2:0];

  // Per-digit next state. A write in the frame-start cycle overrides the clear
  // for its own digit, so the clear effectively happens first.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign shadow_d[gi]  = (wr_en && (wr_idx == 3'(gi))) ? data :
                           (frame_start ? 4'd0 : shadow_q[gi]);
    assign display_d[gi] = commit ? shadow_q[gi] : display_q[gi];
  end

  // Error flag: set by status 00, cleared only by a successful commit.
  always_comb begin
    err_d = err_q;
    if (commit) begin
      err_d = 1'b0;
    end else if (status == ST_ERR) begin
      err_d = 1'b1;
    end
  end

  // Scan timing: the digit index advances when the refresh counter wraps.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CW'(1);
    scan_idx_d    = scan_idx_q;
    if (refresh_cnt_q == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt_d = '0;
      scan_idx_d    = scan_idx_q + 3'd1;
    end
  end

`ifdef DISP_LZB_EN
  // Index of the highest non-zero display digit (0 when all are zero), so
  // digit 0 is never blanked. Codes 10..15 count as non-zero.
  logic [2:0] lzb_hi;
  always_comb begin
    lzb_hi = 3'd0;
    for (int i = 1; i < NDIG; i++) begin
      if (display_q[i] != 4'd0) begin
        lzb_hi = 3'(i);
      end
    end
  end
`endif

  // Anode and segment pattern for the current scan slot. Both are registered
  // together from the same index so they change on the same edge.
  always_comb begin
    an_d = ~(8'b1 << scan_idx_q);
    if (err_q) begin
      case (scan_idx_q)
        3'd0, 3'd1: seg_d = SEG_R;
        3'd2:       seg_d = SEG_E;
        default:    seg_d = SEG_BLANK;
      endcase
    end else begin
      seg_d = bcd_to_seg(display_q[scan_idx_q]);
`ifdef DISP_LZB_EN
      if (scan_idx_q > lzb_hi) begin
        seg_d = SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_q      <= ST_READY;
      err_q         <= 1'b0;
      refresh_cnt_q <= '0;
      scan_idx_q    <= 3'd0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i]  <= 4'd0;
        display_q[i] <= 4'd0;
      end
    end else begin
      status_q      <= status;
      err_q         <= err_d;
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i]  <= shadow_d[i];
        display_q[i] <= display_d[i];
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign err = err_q;

endmodule

// File: tb/tb_disp_mux8.sv
// tb_disp_mux8 -- directed plus randomized bench for disp_mux8 (REFRESH_DIV=4).
// The reference model keeps the shadow/display contents as plain arrays updated
// from the status/data/pos rules, and derives the expected pattern of any digit
// from a segment table.

module tb_disp_mux8;

  logic       clk;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  disp_mux8 #(.REFRESH_DIV(4)) dut (
    .clock  (clk),
    .reset  (reset),
    .status (status),
    .data   (data),
    .pos    (pos),
    .an     (an),
    .seg    (seg),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         m_sh   [8];
  int         m_disp [8];
  bit         m_err;
  logic [1:0] m_stq;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int k);
    int hi;
    if (m_err) begin
      if (k == 2) return 7'b0000110;
      if (k < 2)  return 7'b0101111;
      return 7'b1111111;
    end
    hi = 0;
    for (int i = 0; i < 8; i++) if (m_disp[i] != 0) hi = i;
`ifdef DISP_LZB_EN
    if (k > hi) return 7'b1111111;
`endif
    if (m_disp[k] > 9) return 7'b1111111;
    return seg_tab[m_disp[k]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sh[i]   = 0;
      m_disp[i] = 0;
    end
    m_err = 0;
    m_stq = 2'b10;
  endtask

  // Drive one cycle of inputs and apply the same rules to the model.
  task automatic step(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
    status = st;
    data   = d;
    pos    = p;
    if (st == 2'b11 && m_stq != 2'b11)
      for (int i = 0; i < 8; i++) m_sh[i] = 0;
    if (st == 2'b11 && p >= 1 && p <= 8) m_sh[p-1] = d;
    if (st == 2'b10 && m_stq == 2'b11) begin
      for (int i = 0; i < 8; i++) m_disp[i] = m_sh[i];
      m_err = 0;
    end
    if (st == 2'b00) m_err = 1;
    m_stq = st;
    @(negedge clk);
  endtask

  // Let outputs settle, then watch a little over one full scan frame.
  task automatic scan_check(input string tag);
    int k;
    step(status, 4'd0, 4'd0);
    step(status, 4'd0, 4'd0);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      k = 0;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) k = i;
      chk({tag, "_an_onehot"}, 32'($onehot(~an)), 32'd1);
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(k)));
    end
  endtask

  task automatic send_frame(input int digs [8]);
    step(2'b10, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) step(2'b11, 4'(digs[i]), 4'(i + 1));
    step(2'b10, 4'd0, 4'd0);
  endtask

  int  digs [8];
  bit  found;
  int  n_wr;
  int  ending;

  initial begin
    status = 2'b10;
    data   = 4'd0;
    pos    = 4'd0;
    reset  = 1'b0;
    model_reset();

    // 1: reset values, then the anode walk
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_err", 32'(err), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      chk("walk_an", 32'(an), 32'(8'(~(8'b1 << ((i / 4) % 8)))));
      chk("walk_seg", 32'(seg), 32'(7'b1000000));
    end
    @(negedge clk);

    // 2: frame 3,2,1,0,0,0,0,0
    digs = '{3, 2, 1, 0, 0, 0, 0, 0};
    send_frame(digs);
    scan_check("frame321");

    // 3: aborted frame with error, then recovery
    step(2'b10, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) step(2'b11, 4'(i + 5), 4'(i + 1));
    step(2'b00, 4'd0, 4'd0);
    chk("err_set", 32'(err), 32'd1);
    scan_check("errframe");
    digs = '{4, 5, 6, 0, 0, 0, 0, 0};
    send_frame(digs);
    chk("err_clr", 32'(err), 32'd0);
    scan_check("recover");

    // 4: blank code and ignored positions
    step(2'b10, 4'd0, 4'd0);
    step(2'b11, 4'd1, 4'd1);
    step(2'b11, 4'd7, 4'd0);
    step(2'b11, 4'd12, 4'd3);
    step(2'b11, 4'd7, 4'd9);
    step(2'b11, 4'd2, 4'd5);
    step(2'b11, 4'd7, 4'd15);
    step(2'b10, 4'd0, 4'd0);
    scan_check("ignored");

    // 6: two consecutive frames; the second must not inherit digits
    digs = '{8, 7, 6, 5, 4, 3, 2, 1};
    send_frame(digs);
    scan_check("frame1");
    step(2'b10, 4'd0, 4'd0);
    step(2'b11, 4'd9, 4'd1);
    step(2'b10, 4'd0, 4'd0);
    scan_check("frame2");

    // Randomized frames: random lengths, invalid positions, repeats, aborts
    for (int f = 0; f < 8; f++) begin
      step(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01, 4'd0, 4'd0);
      n_wr = $urandom_range(1, 12);
      for (int w = 0; w < n_wr; w++)
        step(2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 10)));
      ending = $urandom_range(0, 3);
      if (ending == 0)      step(2'b00, 4'd0, 4'd0);
      else if (ending == 1) step(2'b01, 4'd0, 4'd0);
      else                  step(2'b10, 4'd0, 4'd0);
      step(2'b10, 4'd0, 4'd0);
      chk("rnd_err", 32'(err), 32'(m_err));
      scan_check("random");
    end

    // 5: asynchronous reset mid-frame while digit 5 is scanned
    found = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      if (an == 8'hDF) found = 1;
      else step(2'b10, 4'd0, 4'd0);
    end
    chk("wait_digit5", 32'(found), 32'd1);
    status = 2'b11;
    data   = 4'd6;
    pos    = 4'd2;
    #2;
    reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hFF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_err", 32'(err), 32'd0);
    status = 2'b10;
    pos    = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_an", 32'(an), 32'hFE);
    scan_check("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
